ofdm_cp_insert: RTL and testbench
=================================

Name: ofdm_cp_insert

Overview:
- Upstream stage of the DUC/DDC chain. Receives time-domain OFDM symbols from the IFFT, NFFT samples per symbol.
- Prepends a cyclic prefix, which is a copy of the last CP_LEN samples, to each symbol.
- Emits NFFT+CP_LEN samples per symbol on an AXI-Stream master. This master connects directly to the DUC S_AXIS port.
- Uses ping-pong symbol buffering, so one symbol can be written while the previous one is read out.

Parameters:
- NFFT, 4096: samples per OFDM symbol. Power of 2, at least 8.
- CP_LEN, 256: cyclic prefix length. Range 1 to NFFT-1.
- DATA_W, 32: sample width. Q is in [31:16], I is in [15:0], both signed 16-bit.

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  DATA_W  input sample from the IFFT.
- s_axis_tvalid  in  1  input sample valid.
- s_axis_tready  out  1  block can accept an input sample.
- s_axis_tlast  in  1  marks the last sample of an input symbol.
- m_axis_tdata  out  DATA_W  output sample to the DUC.
- m_axis_tvalid  out  1  output sample valid.
- m_axis_tready  in  1  DUC can accept an output sample.
- m_axis_tlast  out  1  marks the last sample of an output symbol (CP included).
- m_axis_tkeep  out  DATA_W/8  all ones whenever m_axis_tvalid=1.
- err_tlast  out  1  sticky flag for input framing mismatch.
- sym_count  out  16  number of completed output symbols. Wraps modulo 2^16.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - s_axis_tready=0 during reset, then 1 on the first cycle after release.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - err_tlast=0, sym_count=0.
  - Both banks EMPTY, write bank=0, read bank=0, all counters 0.
  - Reset mid-symbol discards all buffered and in-flight data with no partial output.
- Storage: two banks of NFFT×DATA_W simple dual-port RAM with 1-cycle read latency. Each bank is either EMPTY or FULL.
- Write side:
  - s_axis_tready=1 iff the current write bank is EMPTY.
  - On each handshake, data is written to the write bank at wr_addr, and wr_addr increments.
  - At wr_addr=NFFT-1 the handshake marks the bank FULL, toggles the write bank, and clears wr_addr to 0.
  - Framing comes from the count only. If s_axis_tlast differs from (wr_addr==NFFT-1) on any handshake, err_tlast is set. It is sticky until reset, and data is still accepted.
- Read FSM states and transitions:
  - IDLE → CP when the read bank is FULL.
  - CP: read addresses NFFT-CP_LEN .. NFFT-1 in order. After issuing NFFT-1 → BODY.
  - BODY: read addresses 0 .. NFFT-1. After issuing NFFT-1, the read bank is marked EMPTY and toggles.
  - From BODY: → CP if the new read bank is FULL, otherwise → IDLE.
  - A read address is issued only when the output pipeline has room. The pipeline is a 2-entry output skid/FIFO after the RAM, so m_axis_tready backpressure never drops or duplicates samples.
- Output:
  - m_axis_tlast=1 only on the body sample read from address NFFT-1.
  - sym_count increments on the m_axis handshake carrying tlast.
  - m_axis_tdata, tlast and tkeep hold stable while tvalid=1 and tready=0.
- Latency: the first output beat has m_axis_tvalid=1 exactly 2 cycles after the cycle in which the input handshake fills a bank (read FSM IDLE, m_axis_tready=1).
- Throughput:
  - With m_axis_tready held at 1 and the next bank FULL in time, consecutive symbols are contiguous. There are no idle cycles between the tlast beat and the next CP beat.
  - Output rate is 1 sample per cycle.
- Simultaneous events:
  - A write filling bank X in the same cycle that the read side frees bank Y: both take effect, and neither is lost.
  - A write into a bank in the same cycle that the bank is freed by the reader cannot happen, because tready was 0 for that bank that cycle.
- Both banks FULL: s_axis_tready=0 until the read side frees a bank. The freed bank accepts input on the following cycle.

Test Plan:
- NFFT=16, CP_LEN=4, input samples with I=k, Q=-k for k=0..15, m_axis_tready=1:
  - Output is 20 beats: I=12,13,14,15,0,1,…,15.
  - tlast only on beat 20; sym_count=1.
  - First tvalid occurs 2 cycles after the 16th input handshake.
- Three back-to-back symbols (NFFT=16, CP_LEN=4), input continuous, m_axis_tready=1:
  - 60 output beats with no tvalid gaps after the first.
  - s_axis_tready deasserts only while both banks are FULL.
  - sym_count=3.
- Random m_axis_tready (50% duty), random s_axis_tvalid:
  - Output sequence is bit-exact against the model (CP copy plus symbol).
  - tdata and tlast are stable during stalls.
- s_axis_tlast asserted at sample 9 of 16:
  - err_tlast=1 from the next cycle and remains set.
  - Framing is still at 16 samples; output is 20 beats.
- aresetn pulsed low mid-CP of symbol 2:
  - tvalid=0 immediately; sym_count=0.
  - After release, a fresh symbol produces a correct 20-beat output.
- Defaults (NFFT=4096, CP_LEN=256), one symbol from the TxIfftSamples1 file:
  - 4352 output beats; beats 0..255 equal input samples 3840..4095.

Source files
------------

// File: rtl/ofdm_cp_insert.sv
// ofdm_cp_insert
// Cyclic-prefix inserter between the IFFT and the DUC. Each incoming
// NFFT-sample symbol is stored in one of two ping-pong banks. While the
// next symbol is written into the other bank, the stored symbol is read
// out as CP_LEN prefix samples (the tail of the symbol) followed by the
// full symbol, so every output symbol is NFFT+CP_LEN beats long.
//
// Handshake semantics (both AXI-Stream ports): a beat transfers on a
// rising clock edge where tvalid=1 and tready=1. A master never waits
// for tready before raising tvalid. Once tvalid=1, tdata/tlast/tkeep are
// held unchanged until the beat transfers.
//
// Read pipeline: the read FSM issues one RAM address per cycle. The RAM
// read data lands directly in a 2-entry output FIFO one cycle later. An
// address is issued only when that FIFO has a free slot at the same edge
// (not full, or popping this cycle), so backpressure never drops or
// duplicates samples.

module ofdm_cp_insert #(
  parameter int NFFT   = 4096,
  parameter int CP_LEN = 256,
  parameter int DATA_W = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // Input stream from the IFFT
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  // Output stream to the DUC
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  // Status
  output logic                  err_tlast,
  output logic [15:0]           sym_count,
  // Debug visibility of the read FSM and bank occupancy
  output logic [1:0]            dbg_rd_state,
  output logic [1:0]            dbg_bank_full
);

  localparam int AW = $clog2(NFFT);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NFFT - 1);
  localparam logic [AW-1:0] CP_START  = AW'(NFFT - CP_LEN);

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_CP   = 2'd1,
    RD_BODY = 2'd2
  } rd_state_e;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic                 init_q;        // low until the first edge after reset release
  logic [1:0]           bank_full_q;   // 1 = bank holds a complete symbol
  logic [1:0]           bank_full_d;
  logic                 wr_bank_q;
  logic [AW-1:0]        wr_addr_q;
  logic                 err_q;

  rd_state_e            rd_state_q;
  logic                 rd_bank_q;
  logic [AW-1:0]        rd_addr_q;

  logic [DATA_W-1:0]    fifo_data_q [2];
  logic [1:0]           fifo_last_q;
  logic                 fifo_wptr_q;
  logic                 fifo_rptr_q;
  logic [1:0]           fifo_cnt_q;
  logic [1:0]           fifo_cnt_d;

  logic [15:0]          sym_cnt_q;

  // Symbol storage: bank index is the address MSB
  logic [DATA_W-1:0]    mem [0:2*NFFT-1];

  // ---------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------
  logic                 s_hs;
  logic                 wr_fill;
  logic                 m_pop;
  logic                 fifo_room;
  logic                 rd_issue;
  logic                 rd_in_body;
  logic [AW-1:0]        rd_cur_addr;
  logic                 rd_at_end;
  logic                 rd_free;

  // The write bank is accepting only while it is empty
  assign s_axis_tready = init_q & ~bank_full_q[wr_bank_q];
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  assign wr_fill       = s_hs & (wr_addr_q == LAST_ADDR);

  assign m_axis_tvalid = (fifo_cnt_q != 2'd0);
  assign m_pop         = m_axis_tvalid & m_axis_tready;
  assign fifo_room     = (fifo_cnt_q != 2'd2) | m_pop;

  // IDLE reads the first prefix address in the same cycle it sees a full
  // bank, which keeps the fill-to-first-beat latency at two cycles.
  assign rd_in_body  = (rd_state_q == RD_BODY);
  assign rd_cur_addr = (rd_state_q == RD_IDLE) ? CP_START : rd_addr_q;
  assign rd_at_end   = (rd_cur_addr == LAST_ADDR);
  assign rd_issue    = bank_full_q[rd_bank_q] & fifo_room;
  assign rd_free     = rd_issue & rd_in_body & rd_at_end;

  assign m_axis_tdata  = fifo_data_q[fifo_rptr_q];
  assign m_axis_tlast  = fifo_last_q[fifo_rptr_q] & m_axis_tvalid;
  assign m_axis_tkeep  = '1;
  assign err_tlast     = err_q;
  assign sym_count     = sym_cnt_q;
  assign dbg_rd_state  = rd_state_q;
  assign dbg_bank_full = bank_full_q;

  // Bank occupancy: a fill and a free can land in the same cycle on
  // different banks; both updates are applied.
  always_comb begin
    bank_full_d = bank_full_q;
    if (wr_fill) bank_full_d[wr_bank_q] = 1'b1;
    if (rd_free) bank_full_d[rd_bank_q] = 1'b0;
  end

  // Output FIFO occupancy after this cycle's push (issue) and pop
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    case ({rd_issue, m_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------

  // Ready enable and bank occupancy flags
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      init_q      <= 1'b0;
      bank_full_q <= 2'b00;
    end else begin
      init_q      <= 1'b1;
      bank_full_q <= bank_full_d;
    end
  end

  // Write side: address counter, bank toggle and framing check
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
      err_q     <= 1'b0;
    end else if (s_hs) begin
      if (s_axis_tlast != (wr_addr_q == LAST_ADDR)) begin
        err_q <= 1'b1;
      end
      if (wr_addr_q == LAST_ADDR) begin
        wr_addr_q <= '0;
        wr_bank_q <= ~wr_bank_q;
      end else begin
        wr_addr_q <= wr_addr_q + 1'b1;
      end
    end
  end

  // Symbol RAM write port
  always_ff @(posedge aclk) begin
    if (s_hs) begin
      mem[{wr_bank_q, wr_addr_q}] <= s_axis_tdata;
    end
  end

  // Read FSM: prefix addresses, then the whole symbol, then next bank
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_q <= RD_IDLE;
      rd_bank_q  <= 1'b0;
      rd_addr_q  <= '0;
    end else if (rd_issue) begin
      if (!rd_in_body) begin
        if (rd_at_end) begin
          rd_state_q <= RD_BODY;
          rd_addr_q  <= '0;
        end else begin
          rd_state_q <= RD_CP;
          rd_addr_q  <= rd_cur_addr + 1'b1;
        end
      end else if (rd_at_end) begin
        rd_bank_q <= ~rd_bank_q;
        if (bank_full_q[~rd_bank_q]) begin
          rd_state_q <= RD_CP;
          rd_addr_q  <= CP_START;
        end else begin
          rd_state_q <= RD_IDLE;
          rd_addr_q  <= '0;
        end
      end else begin
        rd_addr_q <= rd_addr_q + 1'b1;
      end
    end
  end

  // Output FIFO: the RAM read lands in the slot at the write pointer
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
      end
      fifo_last_q <= 2'b00;
      fifo_wptr_q <= 1'b0;
      fifo_rptr_q <= 1'b0;
      fifo_cnt_q  <= 2'd0;
    end else begin
      if (rd_issue) begin
        fifo_data_q[fifo_wptr_q] <= mem[{rd_bank_q, rd_cur_addr}];
        fifo_last_q[fifo_wptr_q] <= rd_in_body & rd_at_end;
        fifo_wptr_q              <= ~fifo_wptr_q;
      end
      if (m_pop) begin
        fifo_rptr_q <= ~fifo_rptr_q;
      end
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Completed output symbols, counted on the tlast handshake
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sym_cnt_q <= 16'd0;
    end else if (m_pop && m_axis_tlast) begin
      sym_cnt_q <= sym_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_ofdm_cp_insert.sv
// Bench for ofdm_cp_insert at NFFT=16, CP_LEN=4: single symbol with latency,
// back-to-back symbols, random backpressure, bad input tlast, and reset
// in the middle of a prefix.

module tb_ofdm_cp_insert;

  localparam int NFFT   = 16;
  localparam int CP_LEN = 4;
  localparam int DW     = 32;
  localparam int TMO    = 400;

  // Clock / reset / DUT signals
  logic          aclk;
  logic          aresetn;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [DW/8-1:0] m_axis_tkeep;
  logic          err_tlast;
  logic [15:0]   sym_count;
  logic [1:0]    dbg_rd_state;
  logic [1:0]    dbg_bank_full;

  // Scoreboard and bookkeeping
  logic [DW:0]   exp_q[$];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  int            beat_cnt = 0;
  int            tl_done = 0;
  int            wr_syms = 0;
  int            gap_cnt = 0;
  int            first_cyc = 0;
  int            last_hs_cyc = 0;
  bit            first_seen = 0;
  bit            chk_ready = 0;
  bit            chk_gaps = 0;
  bit            rnd_ready = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  ofdm_cp_insert #(
    .NFFT   (NFFT),
    .CP_LEN (CP_LEN),
    .DATA_W (DW)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tkeep  (m_axis_tkeep),
    .err_tlast     (err_tlast),
    .sym_count     (sym_count),
    .dbg_rd_state  (dbg_rd_state),
    .dbg_bank_full (dbg_bank_full)
  );

  // Clock and cycle index
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Output backpressure driver
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pop, stall stability, ready and gap models
  always @(negedge aclk) begin
    logic [DW:0] e;
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", m_axis_tvalid, 1'b1);
        chk("stall_data", m_axis_tdata, prev_data);
        chk("stall_last", m_axis_tlast, prev_last);
      end
      if (chk_ready) begin
        chk("s_tready_model", s_axis_tready,
            ((wr_syms - tl_done - ((m_axis_tvalid && m_axis_tlast) ? 1 : 0)) < 2));
      end
      if (chk_gaps && beat_cnt > 0 && beat_cnt < 3*(NFFT+CP_LEN) && !m_axis_tvalid) begin
        gap_cnt++;
      end
      if (m_axis_tvalid) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          first_cyc  = cyc;
        end
        chk("m_tkeep", m_axis_tkeep, {(DW/8){1'b1}});
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_beat: observed=0x%0h expected=none", m_axis_tdata);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("m_tdata", m_axis_tdata, e[DW-1:0]);
          chk("m_tlast", m_axis_tlast, e[DW]);
        end
        beat_cnt++;
        if (m_axis_tlast) tl_done++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  // Drive one NFFT-sample symbol; push the expected CP+symbol beats once filled
  task automatic send_sym(input int base, input int bad_last_idx,
                          input bit rnd_valid, input bit rnd_data);
    logic [DW-1:0] smp [NFFT];
    logic [15:0]   iv;
    logic [15:0]   qv;
    bit            got;
    int            t;
    int            hcyc;
    for (int k = 0; k < NFFT; k++) begin
      iv = 16'(base + k);
      qv = 16'd0 - iv;
      smp[k] = rnd_data ? DW'($urandom) : {qv, iv};
    end
    hcyc = 0;
    for (int k = 0; k < NFFT; k++) begin
      if (rnd_valid) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge aclk);
          #1;
        end
      end
      s_axis_tdata  = smp[k];
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (k == NFFT-1) || (k == bad_last_idx);
      got = 1'b0;
      t   = 0;
      while (!got && t < TMO) begin
        @(negedge aclk);
        got  = s_axis_tready;
        hcyc = cyc;
        @(posedge aclk);
        #1;
        t++;
      end
      chk("s_handshake", got, 1'b1);
      if (!got) begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        return;
      end
      if (k == bad_last_idx) chk("err_tlast_set", err_tlast, 1'b1);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    last_hs_cyc   = hcyc;
    for (int j = NFFT-CP_LEN; j < NFFT; j++) exp_q.push_back({1'b0, smp[j]});
    for (int j = 0; j < NFFT; j++) exp_q.push_back({(j == NFFT-1), smp[j]});
    wr_syms++;
  endtask

  // Wait for n output beats, then check nothing extra arrives
  task automatic wait_beats(input int n);
    int t;
    t = 0;
    while (beat_cnt < n && t < 3000) begin
      @(posedge aclk);
      t++;
    end
    chk("beats_reached", (beat_cnt >= n), 1'b1);
    repeat (4) @(posedge aclk);
    #1;
    chk("beat_count", beat_cnt, n);
    chk("queue_empty", exp_q.size(), 0);
    chk("sym_count", sym_count, 16'(wr_syms));
  endtask

  // Directed sequence
  initial begin
    int t;
    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_s_tready", s_axis_tready, 1'b0);
    chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_m_tlast", m_axis_tlast, 1'b0);
    chk("rst_m_tdata", m_axis_tdata, 32'd0);
    chk("rst_err_tlast", err_tlast, 1'b0);
    chk("rst_sym_count", sym_count, 16'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    chk("s_tready_after_release", s_axis_tready, 1'b1);
    @(posedge aclk);
    #1;

    // Single symbol, latency from the filling handshake
    beat_cnt   = 0;
    first_seen = 1'b0;
    chk_ready  = 1'b1;
    send_sym(0, -1, 1'b0, 1'b0);
    wait_beats(NFFT + CP_LEN);
    chk("first_beat_latency", first_cyc, last_hs_cyc + 2);

    // Three contiguous symbols
    beat_cnt = 0;
    gap_cnt  = 0;
    chk_gaps = 1'b1;
    send_sym(16, -1, 1'b0, 1'b0);
    send_sym(32, -1, 1'b0, 1'b0);
    send_sym(48, -1, 1'b0, 1'b0);
    wait_beats(3 * (NFFT + CP_LEN));
    chk("no_output_gaps", gap_cnt, 0);
    chk_gaps  = 1'b0;
    chk_ready = 1'b0;

    // Random backpressure and random input valid
    rnd_ready = 1'b1;
    beat_cnt  = 0;
    send_sym(0, -1, 1'b1, 1'b1);
    send_sym(0, -1, 1'b1, 1'b1);
    send_sym(0, -1, 1'b1, 1'b1);
    wait_beats(3 * (NFFT + CP_LEN));
    rnd_ready = 1'b0;
    chk("err_tlast_clean", err_tlast, 1'b0);

    // Early tlast on sample 9: flagged, framing unchanged
    beat_cnt = 0;
    send_sym(64, 8, 1'b0, 1'b0);
    wait_beats(NFFT + CP_LEN);
    chk("err_tlast_sticky", err_tlast, 1'b1);

    // Reset in the middle of the second symbol's prefix
    beat_cnt = 0;
    send_sym(80, -1, 1'b0, 1'b0);
    send_sym(96, -1, 1'b0, 1'b0);
    t = 0;
    while (beat_cnt < NFFT + CP_LEN + 2 && t < 1000) begin
      @(posedge aclk);
      t++;
    end
    chk("mid_cp_reached", (beat_cnt >= NFFT + CP_LEN + 2), 1'b1);
    #3;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", m_axis_tvalid, 1'b0);
    chk("mid_rst_sym_count", sym_count, 16'd0);
    chk("mid_rst_s_tready", s_axis_tready, 1'b0);
    chk("mid_rst_err_tlast", err_tlast, 1'b0);
    exp_q.delete();
    wr_syms = 0;
    tl_done = 0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    beat_cnt = 0;
    send_sym(112, -1, 1'b0, 1'b0);
    wait_beats(NFFT + CP_LEN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
